// File: rtl/pwm_sine_multi.sv
// Multi-channel DDS sine-PWM: per-channel phase accumulator + quarter-wave LUT feeding a shared PWM counter.
// Optional dead-time complementary outputs are built when PWM_COMPLEMENT_EN is defined.

module pwm_sine_chan #(
  parameter int PWM_BITS      = 8,
  parameter int ACC_BITS      = 16,
  parameter int LUT_ADDR_BITS = 6,
  parameter int DEAD_CYCLES   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                tick,
  input  logic                wr,
  input  logic [1:0]          wr_reg,
  input  logic [7:0]          wr_data,
  input  logic [PWM_BITS-1:0] cnt,
`ifdef PWM_COMPLEMENT_EN
  output logic                pwm_n,
`endif
  output logic                pwm
);

  localparam int LUT_N = 2 ** LUT_ADDR_BITS;
  localparam int TOP_W = LUT_ADDR_BITS + 2;
  localparam int SUM_W = (TOP_W > 8) ? TOP_W : 8;
  localparam logic [PWM_BITS-1:0] MID = PWM_BITS'(2 ** (PWM_BITS - 1));

  // Q30 fixed-point Taylor series of sin(pi/2 * idx / LUT_N), scaled to M-1 and rounded.
  function automatic logic [PWM_BITS-1:0] lut_val(input int idx);
    longint x, x2, term, s, prod;
    x  = (64'sd1686629713 * idx) >>> LUT_ADDR_BITS;
    x2 = (x * x) >>> 30;
    term = x;
    s    = x;
    for (int k = 1; k < 12; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      s    = s + term;
    end
    prod = (longint'(2 ** (PWM_BITS - 1) - 1) * s + (64'sd1 <<< 29)) >>> 30;
    return PWM_BITS'(prod);
  endfunction

  logic [PWM_BITS-1:0] lut [LUT_N];
  for (genvar i = 0; i < LUT_N; i++) begin : g_lut
    assign lut[i] = lut_val(i);
  end

  logic [15:0]          sh_ftw, ac_ftw;
  logic [7:0]           sh_ph, ac_ph;
  logic [1:0]           sh_ctl, ac_ctl;
  logic [ACC_BITS-1:0]  acc;
  logic [PWM_BITS-1:0]  duty;
  logic                 raw;

  // Phase only touches the top 8 accumulator bits, so lower bits never carry into the sum.
  logic [SUM_W-1:0]         ph_hi;
  logic [TOP_W-1:0]         top;
  logic [1:0]               quad;
  logic [LUT_ADDR_BITS-1:0] idx;
  logic [PWM_BITS-1:0]      lval, sine_val;

  always_comb begin
    ph_hi    = acc[ACC_BITS-1 -: SUM_W] + (SUM_W'(ac_ph) << (SUM_W - 8));
    top      = ph_hi[SUM_W-1 -: TOP_W];
    quad     = top[TOP_W-1 -: 2];
    idx      = quad[0] ? ~top[LUT_ADDR_BITS-1:0] : top[LUT_ADDR_BITS-1:0];
    lval     = lut[idx];
    sine_val = quad[1] ? (MID - lval) : (MID + lval);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_ftw <= '0;
      sh_ph  <= '0;
      sh_ctl <= '0;
      ac_ftw <= '0;
      ac_ph  <= '0;
      ac_ctl <= '0;
      acc    <= '0;
      duty   <= MID;
      raw    <= 1'b0;
    end else begin
      raw <= (cnt < duty);
      if (wr) begin
        case (wr_reg)
          2'd0: sh_ftw[7:0]  <= wr_data;
          2'd1: sh_ftw[15:8] <= wr_data;
          2'd2: sh_ph        <= wr_data;
          default: sh_ctl    <= wr_data[1:0];
        endcase
      end
      // Duty/acc advance with the pre-commit registers; shadow lands for the next period.
      if (tick) begin
        if (ac_ctl[0]) begin
          duty <= sine_val;
          acc  <= acc + ac_ftw[ACC_BITS-1:0];
        end else begin
          duty <= MID;
          acc  <= '0;
        end
        ac_ftw <= sh_ftw;
        ac_ph  <= sh_ph;
        ac_ctl <= sh_ctl;
      end
    end
  end

  logic en_ch, lvl;
  assign en_ch = ena & ac_ctl[0];
  assign lvl   = raw ^ ac_ctl[1];

`ifdef PWM_COMPLEMENT_EN
  localparam int DW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
  logic          prev;
  logic [DW-1:0] dcnt;
  logic          settled;

  // dcnt counts cycles since the last level change; a side may rise only once it has settled.
  always_ff @(posedge clk) begin
    if (!rst_n || !en_ch) begin
      prev <= 1'b0;
      dcnt <= '0;
    end else if (lvl != prev) begin
      prev <= lvl;
      dcnt <= '0;
    end else if (int'(dcnt) < DEAD_CYCLES) begin
      dcnt <= dcnt + DW'(1);
    end
  end

  assign settled = (DEAD_CYCLES == 0) ? 1'b1 : ((lvl == prev) && (int'(dcnt) >= DEAD_CYCLES - 1));
  assign pwm     = en_ch &  lvl & settled;
  assign pwm_n   = en_ch & ~lvl & settled;
`else
  assign pwm = en_ch & lvl;
`endif

endmodule

module pwm_sine_multi #(
  parameter int CHANNELS      = 2,
  parameter int PWM_BITS      = 8,
  parameter int ACC_BITS      = 16,
  parameter int LUT_ADDR_BITS = 6,
  parameter int DEAD_CYCLES   = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ena,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [$clog2(CHANNELS)+2-1:0]   cfg_addr,
  input  logic [7:0]                      cfg_data,
  output logic [CHANNELS-1:0]             pwm_out,
`ifdef PWM_COMPLEMENT_EN
  output logic [CHANNELS-1:0]             pwm_out_n,
`endif
  output logic                            period_tick
);

  localparam int AW = $clog2(CHANNELS) + 2;
  localparam logic [PWM_BITS-1:0] MAX = '1;

  logic [PWM_BITS-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)   cnt <= '0;
    else if (ena) cnt <= cnt + PWM_BITS'(1);
  end

  assign period_tick = ena && (cnt == MAX);
  assign cfg_ready   = 1'b1;

  // Writes addressed past the last channel match no instance and are dropped.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic wr_sel;
    assign wr_sel = cfg_valid && ((cfg_addr >> 2) == AW'(g));

    pwm_sine_chan #(
      .PWM_BITS      (PWM_BITS),
      .ACC_BITS      (ACC_BITS),
      .LUT_ADDR_BITS (LUT_ADDR_BITS),
      .DEAD_CYCLES   (DEAD_CYCLES)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .tick    (period_tick),
      .wr      (wr_sel),
      .wr_reg  (cfg_addr[1:0]),
      .wr_data (cfg_data),
      .cnt     (cnt),
`ifdef PWM_COMPLEMENT_EN
      .pwm_n   (pwm_out_n[g]),
`endif
      .pwm     (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_pwm_sine_multi.sv
// Bench for pwm_sine_multi: cycle model built from the register/tick rules with a real-valued sine.
module tb_pwm_sine_multi;

  localparam int CH  = 2;
  localparam int PB  = 8;
  localparam int AB  = 16;
  localparam int LB  = 6;
  localparam int AW  = $clog2(CH) + 2;
  localparam int MAX = 2 ** PB - 1;
  localparam int M   = 2 ** (PB - 1);
  localparam real PI = 3.14159265358979323846;

  logic          clk = 1'b0;
  logic          rst_n, ena, cfg_valid;
  logic [AW-1:0] cfg_addr;
  logic [7:0]    cfg_data;
  logic          cfg_ready;
  logic [CH-1:0] pwm_out;
  logic          period_tick;
`ifdef PWM_COMPLEMENT_EN
  logic [CH-1:0] pwm_out_n;
`endif

  always #5 clk = ~clk;

  pwm_sine_multi #(.CHANNELS(CH), .PWM_BITS(PB), .ACC_BITS(AB), .LUT_ADDR_BITS(LB), .DEAD_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .pwm_out(pwm_out),
`ifdef PWM_COMPLEMENT_EN
    .pwm_out_n(pwm_out_n),
`endif
    .period_tick(period_tick));

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference state
  int m_cnt;
  int m_acc[CH], m_duty[CH], m_raw[CH];
  int sh_ftw[CH], sh_ph[CH], sh_ct[CH];
  int ac_ftw[CH], ac_ph[CH], ac_ct[CH];

  function automatic int sine_ref(input int p);
    int top, q, i, idx, l;
    top = (p >> (AB - LB - 2)) & ((1 << (LB + 2)) - 1);
    q   = top >> LB;
    i   = top & ((1 << LB) - 1);
    idx = (q % 2 == 1) ? ((1 << LB) - 1 - i) : i;
    l   = $rtoi(real'(M - 1) * $sin(PI / 2.0 * real'(idx) / real'(1 << LB)) + 0.5);
    return (q < 2) ? (M + l) : (M - l);
  endfunction

  function automatic void model_edge();
    bit tick;
    if (!rst_n) begin
      m_cnt = 0;
      for (int c = 0; c < CH; c++) begin
        m_acc[c] = 0; m_duty[c] = M; m_raw[c] = 0;
        sh_ftw[c] = 0; sh_ph[c] = 0; sh_ct[c] = 0;
        ac_ftw[c] = 0; ac_ph[c] = 0; ac_ct[c] = 0;
      end
      return;
    end
    tick = (m_cnt == MAX) && ena;
    for (int c = 0; c < CH; c++) m_raw[c] = (m_cnt < m_duty[c]) ? 1 : 0;
    if (tick) begin
      for (int c = 0; c < CH; c++) begin
        if (ac_ct[c] % 2 == 1) begin
          m_duty[c] = sine_ref((m_acc[c] + (ac_ph[c] << (AB - 8))) % (1 << AB));
          m_acc[c]  = (m_acc[c] + ac_ftw[c]) % (1 << AB);
        end else begin
          m_acc[c] = 0; m_duty[c] = M;
        end
        ac_ftw[c] = sh_ftw[c]; ac_ph[c] = sh_ph[c]; ac_ct[c] = sh_ct[c];
      end
    end
    if (cfg_valid) begin
      int ch, r;
      ch = int'(cfg_addr) >> 2;
      r  = int'(cfg_addr) & 3;
      if (ch < CH) begin
        case (r)
          0: sh_ftw[ch] = (sh_ftw[ch] & 16'hFF00) | int'(cfg_data);
          1: sh_ftw[ch] = (sh_ftw[ch] & 16'h00FF) | (int'(cfg_data) << 8);
          2: sh_ph[ch]  = int'(cfg_data);
          default: sh_ct[ch] = int'(cfg_data) & 3;
        endcase
      end
    end
    if (ena) m_cnt = (m_cnt + 1) % (MAX + 1);
  endfunction

  task automatic cyc();
    logic [CH-1:0] exp_pwm;
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < CH; c++)
      exp_pwm[c] = ena && (ac_ct[c] % 2 == 1) && ((m_raw[c] != 0) ^ (ac_ct[c] >= 2));
    chk("pwm_out", 32'(pwm_out), 32'(exp_pwm));
    chk("period_tick", 32'(period_tick), 32'((m_cnt == MAX) && ena));
    chk("cfg_ready", 32'(cfg_ready), 32'd1);
  endtask

  task automatic wr(input int addr, input int data);
    cfg_valid = 1'b1;
    cfg_addr  = AW'(addr);
    cfg_data  = 8'(data);
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_cnt(input int target);
    for (int k = 0; k < 600; k++) begin
      if (m_cnt == target) return;
      cyc();
    end
    chk("wait_cnt_timeout", 32'd0, 32'd1);
  endtask

  // Counts high samples of each channel up to and including the next tick sample.
  task automatic run_period(output int h0, output int h1);
    h0 = 0; h1 = 0;
    for (int k = 0; k < 600; k++) begin
      cyc();
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      if (period_tick) return;
    end
    chk("period_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int h0, h1, first_tick, second_tick, ntick, highs;
    rst_n = 1'b0; ena = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (3) cyc();
    chk("reset_pwm", 32'(pwm_out), 32'd0);
    chk("reset_tick", 32'(period_tick), 32'd0);

    // Idle run: ticks at 255 and 511 edges after release, outputs low.
    rst_n = 1'b1; ena = 1'b1;
    first_tick = -1; second_tick = -1; ntick = 0; highs = 0;
    for (int k = 1; k <= 600; k++) begin
      cyc();
      highs += int'(pwm_out != 0);
      if (period_tick) begin
        if (ntick == 0) first_tick = k; else if (ntick == 1) second_tick = k;
        ntick++;
      end
    end
    chk("first_tick_cycle", 32'(first_tick), 32'd255);
    chk("second_tick_cycle", 32'(second_tick), 32'd511);
    chk("idle_pwm_high_count", 32'(highs), 32'd0);

    // ch0 FTW=0x0400 enabled: duty walks the sine, peak 255 and minimum 1.
    wr(0, 8'h00); wr(1, 8'h04); wr(3, 8'h01);
    wait_cnt(MAX);
    for (int n = 1; n <= 52; n++) begin
      run_period(h0, h1);
      chk($sformatf("ftw400_duty_p%0d", n), 32'(h0), 32'((n == 1) ? M : sine_ref((n - 2) * 32'h400)));
      if (n == 18) chk("ftw400_peak", 32'(h0), 32'd255);
      if (n == 50) chk("ftw400_min", 32'(h0), 32'd1);
    end

    // Disable, then enable ch0 and ch1 together with ch1 PHASE=0x40.
    wr(3, 8'h00);
    wait_cnt(MAX);
    wr(0, 0); wr(1, 0); wr(4, 0); wr(5, 0); wr(6, 8'h40);
    wr(3, 8'h01); wr(7, 8'h01);
    wait_cnt(MAX);
    run_period(h0, h1);
    run_period(h0, h1);
    chk("aligned_ch0_duty", 32'(h0), 32'd128);
    chk("aligned_ch1_duty", 32'(h1), 32'd255);

    // Invert written one cycle before the tick vs exactly on the tick.
    wait_cnt(MAX - 1);
    wr(7, 8'h03);
    run_period(h0, h1);
    chk("inv_early_next_period", 32'(h1), 32'd1);
    wait_cnt(MAX);
    wr(7, 8'h01);
    run_period(h0, h1);
    chk("inv_ontick_still_inverted", 32'(h1), 32'd0);
    run_period(h0, h1);
    chk("inv_ontick_released", 32'(h1), 32'd255);

    // Mid-period reset with pending shadow writes.
    wait_cnt(100);
    wr(0, 8'h55); wr(1, 8'h12); wr(3, 8'h03); wr(7, 8'h03);
    rst_n = 1'b0;
    cyc();
    chk("midrst_pwm", 32'(pwm_out), 32'd0);
    chk("midrst_tick", 32'(period_tick), 32'd0);
    rst_n = 1'b1;
    highs = 0;
    for (int k = 0; k < 600; k++) begin
      cyc();
      highs += int'(pwm_out != 0);
    end
    chk("no_commit_after_reset", 32'(highs), 32'd0);

    // Random writes (including to the tick cycle) and ena drop-outs.
    wr(3, 8'h01); wr(7, 8'h01);
    for (int k = 0; k < 6000; k++) begin
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_addr  = AW'($urandom_range(0, 2 ** AW - 1));
      cfg_data  = 8'($urandom);
      ena       = ($urandom_range(0, 15) != 0);
      cyc();
    end
    cfg_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
